sys_bus_fabric: RTL and testbench



---
 rtl/sys_bus_fabric.sv | 173 +++++++++++++++++
 tb/tb_sys_bus_fabric.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_fabric.sv
// Single-master address decoder and response multiplexer toward N memory-mapped slaves.
// Table-driven region map, valid/ready slave handshake, per-access timeout and sticky error capture.
module sys_bus_fabric #(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {32'hFFFFFFFF, 32'h80000000, 32'h02000000, 32'h00002000},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {32'h00000000, 32'h80000000, 32'hFFFF0000, 32'hFFFFF000},
  parameter logic [N_SLV-1:0]    SLV_EN   = 4'b0111,
  parameter int                  TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_valid,
  input  logic                m_write,
  input  logic [31:0]         m_addr,
  input  logic [31:0]         m_wdata,
  output logic                m_ready,
  output logic                m_err,
  output logic [31:0]         m_rdata,
  output logic [N_SLV-1:0]    s_valid,
  output logic                s_write,
  output logic [31:0]         s_addr,
  output logic [31:0]         s_wdata,
  input  logic [N_SLV-1:0]    s_ready,
  input  logic [N_SLV*32-1:0] s_rdata,
  input  logic                err_clr,
  output logic                err_flag,
  output logic [31:0]         err_addr
);

  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_SLV-1:0]  s_valid_q, s_valid_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              eflag_q, eflag_d;
  logic [31:0]       eaddr_q, eaddr_d;

  logic [N_SLV-1:0]  hit;
  logic [SW-1:0]     hit_sel;
  logic              any_hit;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic [CW-1:0]     cnt_inc;
  logic              timeout_hit;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_dec
    assign hit[gi] = SLV_EN[gi] &&
                     ((m_addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32]);
  end

  // Scan downward so the lowest-indexed hitting region is the one left standing.
  always_comb begin
    hit_sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) hit_sel = SW'(i);
    end
  end

  assign any_hit     = |hit;
  assign sel_ready   = s_ready[sel_q];
  assign sel_rdata   = s_rdata[32*sel_q +: 32];
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    s_valid_d = s_valid_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    eflag_d   = err_clr ? 1'b0 : eflag_q;
    eaddr_d   = eaddr_q;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          write_d = m_write;
          if (any_hit) begin
            sel_d     = hit_sel;
            s_valid_d = N_SLV'(1) << hit_sel;
            cnt_d     = '0;
            state_d   = ACCESS;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            eflag_d = 1'b1;
            eaddr_d = m_addr;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // A ready arriving on the final allowed cycle takes precedence over the timeout.
        if (sel_ready) begin
          ready_d   = 1'b1;
          rdata_d   = write_q ? 32'h0 : sel_rdata;
          s_valid_d = '0;
          cnt_d     = '0;
          state_d   = RESP;
        end else if (timeout_hit) begin
          ready_d   = 1'b1;
          err_d     = 1'b1;
          eflag_d   = 1'b1;
          eaddr_d   = addr_q;
          s_valid_d = '0;
          cnt_d     = '0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      s_valid_q <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      eflag_q   <= 1'b0;
      eaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      s_valid_q <= s_valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      eflag_q   <= eflag_d;
      eaddr_q   <= eaddr_d;
    end
  end

  assign m_ready  = ready_q;
  assign m_err    = err_q;
  assign m_rdata  = rdata_q;
  assign s_valid  = s_valid_q;
  assign s_write  = write_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign err_flag = eflag_q;
  assign err_addr = eaddr_q;

endmodule

// File: tb/tb_sys_bus_fabric.sv
// Scoreboard bench for sys_bus_fabric: directed scenarios followed by randomized traffic,
// checked against a region-map reference model with behavioural slave responders.
module tb_sys_bus_fabric;

  localparam int NS = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m_valid, m_write, m_ready, m_err;
  logic [31:0]     m_addr, m_wdata, m_rdata;
  logic [NS-1:0]   s_valid, s_ready;
  logic            s_write;
  logic [31:0]     s_addr, s_wdata;
  logic [NS*32-1:0] s_rdata;
  logic            err_clr, err_flag;
  logic [31:0]     err_addr;

  // Slot 1 spans 0x00000000-0x03FFFFFF so it overlaps slot 0 and also covers 0x02000004.
  sys_bus_fabric #(
    .N_SLV   (NS),
    .SLV_BASE({32'h10000000, 32'h80000000, 32'h00000000, 32'h00002000}),
    .SLV_MASK({32'hF0000000, 32'h80000000, 32'hFC000000, 32'hFFFFF000}),
    .SLV_EN  (4'b0111),
    .TIMEOUT (TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          svc;
    logic        flag;
    logic [31:0] eaddr;
    int          issue;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ntxn = 0;
  bit          abort = 0;
  logic        mdl_flag = 1'b0;
  logic [31:0] mdl_eaddr = 32'h0;
  logic [31:0] slave_data[NS];
  int          slave_wait[NS];
  int          scnt[NS];

  logic [31:0] ref_base[NS] = '{32'h00002000, 32'h00000000, 32'h80000000, 32'h10000000};
  logic [31:0] ref_mask[NS] = '{32'hFFFFF000, 32'hFC000000, 32'h80000000, 32'hF0000000};
  bit          ref_en[NS]   = '{1'b1, 1'b1, 1'b1, 1'b0};

  for (genvar gi = 0; gi < NS; gi++) begin : g_rd
    assign s_rdata[32*gi +: 32] = slave_data[gi];
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (ref_en[i] && ((a & ref_mask[i]) == ref_base[i])) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slaves: selected one answers after slave_wait cycles; idle ones toggle s_ready at random.
  initial begin
    s_ready = '0;
    for (int i = 0; i < NS; i++) begin scnt[i] = 0; slave_wait[i] = 0; slave_data[i] = 32'h0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (!rst_n) begin
          scnt[i] = 0; s_ready[i] = 1'b0;
        end else if (s_valid[i]) begin
          s_ready[i] = (scnt[i] == slave_wait[i]);
          scnt[i]++;
        end else begin
          scnt[i] = 0; s_ready[i] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: tracks the slave-side handshake and scores every master response.
  initial begin
    int sv_cnt = 0;
    bit sv_bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sv_cnt = 0; sv_bad = 0;
      end else begin
        if (s_valid != '0) begin
          sv_cnt++;
          if (q.size() == 0) sv_bad = 1;
          else if (q[0].slot < 0 || s_valid != (NS'(1) << q[0].slot) ||
                   s_addr != q[0].addr || s_write != q[0].wr || s_wdata != q[0].wdata)
            sv_bad = 1;
        end
        if (m_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: got m_ready=1 with no request outstanding");
          end else begin
            e = q.pop_front();
            ntxn++;
            $display("txn %0d %s addr=%h slot=%0d err=%0b rdata=%h lat=%0d",
                     ntxn, e.wr ? "WR" : "RD", e.addr, e.slot, m_err, m_rdata, cyc - e.issue);
            chk("m_err", 32'(m_err), 32'(e.err));
            chk("m_rdata", m_rdata, e.rdata);
            chk("latency", 32'(cyc - e.issue), 32'(e.lat));
            chk("s_valid_cycles", 32'(sv_cnt), 32'(e.svc));
            chk("slave_side_fields", 32'(sv_bad), 32'h0);
            chk("err_flag", 32'(err_flag), 32'(e.flag));
            chk("err_addr", err_addr, e.eaddr);
          end
          sv_cnt = 0; sv_bad = 0;
        end
      end
    end
  end

  function automatic exp_t predict(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                   input int w);
    exp_t e;
    e.slot = decode(a); e.wr = wr; e.addr = a; e.wdata = wd;
    e.rdata = 32'h0; e.issue = cyc;
    if (e.slot < 0) begin
      e.err = 1'b1; e.lat = 1; e.svc = 0;
    end else if (w >= TO) begin
      e.err = 1'b1; e.lat = TO + 1; e.svc = TO;
    end else begin
      e.err = 1'b0; e.lat = w + 2; e.svc = w + 1;
      if (!wr) e.rdata = slave_data[e.slot];
    end
    return e;
  endfunction

  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int w, input logic clr, input bit use_fix, input logic [31:0] fix);
    exp_t e;
    bit   got = 0;
    int   s;
    @(negedge clk);
    s = decode(a);
    for (int i = 0; i < NS; i++) begin
      slave_wait[i] = w;
      slave_data[i] = ($urandom & 32'hFFFFFFF0) | 32'(i);
    end
    if (use_fix && s >= 0) slave_data[s] = fix;
    e = predict(wr, a, wd, w);
    if (e.err) begin mdl_flag = 1'b1; mdl_eaddr = a; end
    else if (clr) mdl_flag = 1'b0;
    e.flag = mdl_flag; e.eaddr = mdl_eaddr;
    q.push_back(e);
    m_valid = 1'b1; m_write = wr; m_addr = a; m_wdata = wd; err_clr = clr;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (m_ready) got = 1;
    end
    m_valid = 1'b0;
    if (!got) begin
      checks++; errors++; abort = 1;
      $display("FAIL handshake_timeout: got no m_ready within 40 cycles, expected one for addr %h", a);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'h0);
    chk({tag, "_m_ready"}, 32'(m_ready), 32'h0);
    chk({tag, "_m_err"}, 32'(m_err), 32'h0);
    chk({tag, "_m_rdata"}, m_rdata, 32'h0);
    chk({tag, "_s_addr"}, s_addr, 32'h0);
    chk({tag, "_s_wdata"}, s_wdata, 32'h0);
    chk({tag, "_s_write"}, 32'(s_write), 32'h0);
    chk({tag, "_err_flag"}, 32'(err_flag), 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    #2 rst_n = 1'b1;

    // RAM read, zero wait; APB write, 3 waits; decode misses (unmapped and disabled slot).
    do_txn(1'b0, 32'h00002010, 32'h0, 0, 1'b0, 1'b1, 32'h12345678);
    do_txn(1'b1, 32'h80000004, 32'hCAFEF00D, 3, 1'b0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h40000000, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h10000010, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    // Timeout, then ready arriving on the last allowed cycle.
    do_txn(1'b0, 32'h02000004, 32'h0, 255, 1'b1, 1'b0, 32'h0);
    do_txn(1'b0, 32'h02000004, 32'h0, TO - 1, 1'b0, 1'b1, 32'hA5A5_0001);
    // Overlap priority, then clear coinciding with a new miss.
    do_txn(1'b0, 32'h00002000, 32'h0, 1, 1'b0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h40000100, 32'h0, 0, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a waited access.
    if (!abort) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) slave_wait[i] = 5;
      e = predict(1'b0, 32'h80000100, 32'h0, 5);
      q.push_back(e);
      m_valid = 1'b1; m_write = 1'b0; m_addr = 32'h80000100; m_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("pre_reset_s_valid", 32'(s_valid), 32'h4);
      #2 rst_n = 1'b0;
      #1 reset_checks("midreset");
      m_valid = 1'b0;
      q.delete();
      mdl_flag = 1'b0; mdl_eaddr = 32'h0;
      @(posedge clk);
      #2 chk("held_reset_s_valid", 32'(s_valid), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      do_txn(1'b0, 32'h80000200, 32'h0, 2, 1'b0, 1'b1, 32'hBEEF_0042);
    end

    // Randomized traffic across every region class, wait profile and clear timing.
    for (int n = 0; n < 60 && !abort; n++) begin
      logic [31:0] a;
      int          w;
      case ($urandom_range(0, 5))
        0: a = 32'h00002000 | ($urandom & 32'h00000FFC);
        1: a = $urandom & 32'h03FFFFFC;
        2: a = 32'h80000000 | ($urandom & 32'h7FFFFFFC);
        3: a = 32'h40000000 | ($urandom & 32'h3FFFFFFC);
        4: a = 32'h10000000 | ($urandom & 32'h0FFFFFFC);
        default: a = 32'h02000000 | ($urandom & 32'h0000FFFC);
      endcase
      w = $urandom_range(0, 9);
      if (w == 9) w = 255;
      do_txn(1'($urandom_range(0, 1)), a, $urandom, w, ($urandom_range(0, 3) == 0), 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations: got %0d unanswered, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
